// File: rtl/josh_pkg.sv
// Shared constants and types for the level-map column feeder.
// Holds the column geometry, map size, scroll divider and FSM state type.
package josh_pkg;

  localparam int COL_W       = 100;
  localparam int SCREEN_COLS = 120;
  localparam int MAP_DEPTH   = 512;
  localparam int TICK_DIV    = 1666666;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/shift_tick_gen.sv
// Scroll strobe divider: one-cycle pulse every TICK_DIV enabled cycles.
// Async active-low reset; clr restarts the count synchronously.
module shift_tick_gen #(
  parameter int TICK_DIV = josh_pkg::TICK_DIV,
  parameter int TICK_W   = 21
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [TICK_W-1:0] TOP = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      if (count == TOP) begin
        count <= '0;
        tick  <= 1'b1;
      end else begin
        count <= count + TICK_W'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/map_column_feeder.sv
// Streams map columns from a 1-cycle-latency ROM through a 2-entry buffer.
// Build option LOOP_MAP_EN: endless map, zero columns dropped, no DONE.
module map_column_feeder #(
  parameter int COL_W     = josh_pkg::COL_W,
  parameter int MAP_DEPTH = josh_pkg::MAP_DEPTH,
  parameter int ADDR_W    = 9,
  parameter int TICK_DIV  = josh_pkg::TICK_DIV,
  parameter int TICK_W    = 21
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [COL_W-1:0]  rom_q,
  output logic              col_valid,
  input  logic              col_ready,
  output logic [COL_W-1:0]  col_data,
  output logic              col_last,
  output logic              shift_tick,
  output logic              map_done
);

  import josh_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(MAP_DEPTH - 1);

  feeder_state_t     state;
  logic [COL_W-1:0]  buf_data [2];
  logic [1:0]        buf_last;
  logic              head;
  logic [1:0]        cnt;
  logic              in_flight;
  logic [ADDR_W-1:0] fl_addr;

  logic pop;
  logic eom;
  logic keep;
  logic issue;
  logic tail;

  always_comb begin
    pop  = col_valid & col_ready;
    eom  = (rom_q == '0) || (fl_addr == LAST_ADDR);
`ifdef LOOP_MAP_EN
    keep = in_flight & (rom_q != '0);
`else
    keep = in_flight;
`endif
    // no read may follow the column that ends the map
    issue = (state == RUN)
          && (({1'b0, cnt} + {2'b0, in_flight}) < 3'd2)
          && !(in_flight && eom);
    tail = head ^ cnt[0];
  end

  assign col_valid = (cnt != 2'd0);
  assign col_data  = buf_data[head];
  assign col_last  = col_valid & buf_last[head];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      rom_addr    <= '0;
      fl_addr     <= '0;
      in_flight   <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= '0;
      head        <= 1'b0;
      cnt         <= '0;
      map_done    <= 1'b0;
    end else if (!enable) begin
      state       <= IDLE;
      rom_addr    <= '0;
      fl_addr     <= '0;
      in_flight   <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= '0;
      head        <= 1'b0;
      cnt         <= '0;
      map_done    <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        fl_addr  <= rom_addr;
        rom_addr <= (rom_addr == LAST_ADDR) ?
                    '0 : rom_addr + ADDR_W'(1);
      end
      if (keep) begin
        buf_data[tail] <= rom_q;
`ifdef LOOP_MAP_EN
        buf_last[tail] <= 1'b0;
`else
        buf_last[tail] <= eom;
`endif
      end
      head <= head ^ pop;
      cnt  <= cnt + {1'b0, keep} - {1'b0, pop};
      unique case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (in_flight && eom) begin
`ifdef LOOP_MAP_EN
            rom_addr <= '0;
`else
            state <= DRAIN;
`endif
          end
        end
        DRAIN: begin
          if (pop && col_last) begin
            state    <= DONE;
            map_done <= 1'b1;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  shift_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .clr    (!enable),
    .en     (enable && (state != DONE)),
    .tick   (shift_tick)
  );

endmodule

// File: tb/tb_map_column_feeder.sv
// Self-checking bench for map_column_feeder with a small 4-word map.
// Column order and flags come from a queue model built from the ROM image.
module tb_map_column_feeder;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic [1:0] rom_addr;
  logic [7:0] rom_q;
  logic       col_valid;
  logic       col_ready;
  logic [7:0] col_data;
  logic       col_last;
  logic       shift_tick;
  logic       map_done;

  logic [7:0] rom [4];

  int checks;
  int failures;

  map_column_feeder #(
    .COL_W     (8),
    .MAP_DEPTH (4),
    .ADDR_W    (2),
    .TICK_DIV  (4),
    .TICK_W    (2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .col_valid  (col_valid),
    .col_ready  (col_ready),
    .col_data   (col_data),
    .col_last   (col_last),
    .shift_tick (shift_tick),
    .map_done   (map_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_addr];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected stream: {last, data}
  logic [8:0] expq [$];
  bit         armed;
  int         n_hs;
  bit         done_seen;
  bit         done_next;
  bit         hold_prev;
  logic [7:0] prev_data;
  logic       prev_last;
  int         max_addr;

  function automatic void build_model();
    expq.delete();
`ifdef LOOP_MAP_EN
    begin
      int a = 0;
      for (int g = 0; g < 400 && expq.size() < 40; g++) begin
        if (rom[a] != 8'h00) expq.push_back({1'b0, rom[a]});
        a = (rom[a] == 8'h00 || a == 3) ? 0 : a + 1;
      end
    end
`else
    for (int a = 0; a < 4; a++) begin
      bit last = (rom[a] == 8'h00) || (a == 3);
      expq.push_back({last, rom[a]});
      if (last) break;
    end
`endif
  endfunction

  task automatic start_run();
    build_model();
    n_hs      = 0;
    done_seen = 0;
    done_next = 0;
    hold_prev = 0;
    max_addr  = 0;
    armed     = 1;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      if (done_next) begin
        check("map_done_rise", {31'd0, map_done}, 32'd1);
        done_next = 0;
        done_seen = 1;
      end else if (!done_seen) begin
        check("map_done_low", {31'd0, map_done}, 32'd0);
      end
      if (col_valid && hold_prev) begin
        check("hold_data", {24'd0, col_data}, {24'd0, prev_data});
        check("hold_last", {31'd0, col_last}, {31'd0, prev_last});
      end
      if (col_valid && col_ready) begin
        if (expq.size() == 0) begin
          check("extra_col", {24'd0, col_data}, 32'hFFFF_FFFF);
        end else begin
          check("col_data", {24'd0, col_data}, {24'd0, expq[0][7:0]});
          check("col_last", {31'd0, col_last}, {31'd0, expq[0][8]});
          if (expq[0][8]) done_next = 1;
          void'(expq.pop_front());
          n_hs++;
        end
      end
      hold_prev = col_valid && !col_ready;
      prev_data = col_data;
      prev_last = col_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    armed     = 0;
    resetn    = 1'b0;
    enable    = 1'b0;
    col_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  task automatic load_rom(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input logic [7:0] w3);
    rom[0] = w0;
    rom[1] = w1;
    rom[2] = w2;
    rom[3] = w3;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"},  {30'd0, rom_addr}, 32'd0);
    check({tag, "_valid"}, {31'd0, col_valid}, 32'd0);
    check({tag, "_data"},  {24'd0, col_data}, 32'd0);
    check({tag, "_last"},  {31'd0, col_last}, 32'd0);
    check({tag, "_tick"},  {31'd0, shift_tick}, 32'd0);
    check({tag, "_done"},  {31'd0, map_done}, 32'd0);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) step();
    check("done_timeout", {31'd0, done_seen}, 32'd1);
  endtask

  task automatic random_ready_run(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) begin
      col_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    col_ready = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    armed    = 0;
    load_rom(8'h81, 8'hC3, 8'hE7, 8'hFF);

    // reset state
    do_reset();
    #1;
    check_idle_outputs("reset");

`ifndef LOOP_MAP_EN
    // 1: full stream at one column per cycle
    start_run();
    enable    = 1'b1;
    col_ready = 1'b1;
    step();
    step();
    #1;
    check("t1_valid_edge2", {31'd0, col_valid}, 32'd0);
    step();
    #1;
    check("t1_valid_edge3", {31'd0, col_valid}, 32'd1);
    check("t1_first_col", {24'd0, col_data}, 32'h81);
    wait_done(30);
    check("t1_count", n_hs, 32'd4);
    check("t1_done", {31'd0, map_done}, 32'd1);
    enable = 1'b0;
    step();
    #1;
    check("t1_done_clear", {31'd0, map_done}, 32'd0);

    // 2: backpressure holds the head and stops issuing
    do_reset();
    start_run();
    enable = 1'b1;
    repeat (10) step();
    #1;
    check("t2_addr_stop", {30'd0, rom_addr}, 32'd2);
    check("t2_valid", {31'd0, col_valid}, 32'd1);
    check("t2_hold81", {24'd0, col_data}, 32'h81);
    col_ready = 1'b1;
    wait_done(30);
    check("t2_count", n_hs, 32'd4);
    check("t2_q_empty", expq.size(), 32'd0);

    // 3: zero column ends the map early
    do_reset();
    load_rom(8'h81, 8'h00, 8'hE7, 8'hFF);
    start_run();
    enable    = 1'b1;
    col_ready = 1'b1;
    wait_done(30);
    check("t3_count", n_hs, 32'd2);
    check("t3_no_addr3", {31'd0, max_addr == 3}, 32'd0);

    // 4: flush with a read in flight, then restart
    do_reset();
    load_rom(8'h81, 8'hC3, 8'hE7, 8'hFF);
    enable = 1'b1;
    step();
    step();
    enable = 1'b0;
    step();
    #1;
    check_idle_outputs("t4_flush");
    step();
    start_run();
    enable    = 1'b1;
    col_ready = 1'b1;
    wait_done(30);
    check("t4_count", n_hs, 32'd4);

    // random backpressure against the model, several ROM images
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int a = 0; a < 4; a++)
        rom[a] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      start_run();
      enable = 1'b1;
      random_ready_run(60);
      wait_done(20);
      check("rand_q_empty", expq.size(), 32'd0);
    end
`else
    // 6: looping map, zero column wraps and is dropped
    load_rom(8'h81, 8'hC3, 8'hE7, 8'h00);
    start_run();
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      col_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    check("t6_count", {31'd0, n_hs >= 6}, 32'd1);
    check("t6_no_done", {31'd0, map_done}, 32'd0);
    check("t6_no_last", {31'd0, col_last}, 32'd0);
`endif

    // 5: scroll strobe timing and async clear
    do_reset();
    load_rom(8'h81, 8'hC3, 8'hE7, 8'hFF);
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      #1;
      check($sformatf("t5_tick_%0d", k), {31'd0, shift_tick},
            {31'd0, (k % 4) == 0});
    end
    resetn = 1'b0;
    #1;
    check("t5_async_clr", {31'd0, shift_tick}, 32'd0);
    check("t5_async_valid", {31'd0, col_valid}, 32'd0);

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
